memory_dp: RTL and testbench

- Parametrised successor to the single-port bidirectional `memory`.
- Simple dual-port synchronous RAM: one write port, one read port, separate unidirectional data buses, per-byte write enables.
- Selectable read-during-write collision mode and an optional post-reset clear sequencer.
- Sits as the generic storage macro under register files, instruction/data memories and FIFOs in the RISC-V core.

---
 rtl/memory_pkg.sv | 18 +
 rtl/memory_clear_seq.sv | 51 +++++
 rtl/memory_dp.sv | 95 +++++++++
 tb/tb_memory_dp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared types and helpers for the dual-port memory macro and its clear sequencer.
package memory_pkg;

  typedef enum logic {
    RD_FIRST = 1'b0,
    WR_FIRST = 1'b1
  } rd_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  function automatic int byte_count(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/memory_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then
// parks in READY until the next reset.
module memory_clear_seq
  import memory_pkg::*;
#(
  parameter int AWIDTH         = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              clr_we_o,
  output logic [AWIDTH-1:0] clr_addr_o,
  output logic              busy_o
);

  mem_state_e        state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The last address is all ones, so the final clear write and the move to
  // READY happen on the same edge.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_we_o   = 1'b0;
    clr_addr_o = ptr_q;
    busy_o     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_o = 1'b1;
        busy_o   = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (&ptr_q) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

endmodule

// File: rtl/memory_dp.sv
// Simple dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour and an optional post-reset clear.
module memory_dp
  import memory_pkg::*;
#(
  parameter int AWIDTH         = 5,
  parameter int DWIDTH         = 8,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [AWIDTH-1:0]     wr_addr_i,
  input  logic [DWIDTH-1:0]     wr_data_i,
  input  logic [DWIDTH/8-1:0]   wr_be_i,
  input  logic                  rd_i,
  input  logic [AWIDTH-1:0]     rd_addr_i,
  output logic [DWIDTH-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o
);

  localparam int DEPTH   = 2 ** AWIDTH;
  localparam int BYTES   = byte_count(DWIDTH);
  localparam bit WrFirst = (RD_MODE == int'(WR_FIRST));

  if (DWIDTH % 8 != 0) begin : g_bad_dwidth
    $fatal(1, "memory_dp: DWIDTH must be a multiple of 8");
  end

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data_q, rd_data_d, rd_word;
  logic              rd_valid_q, rd_valid_d;
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;
  logic              busy;
  logic              wr_fire, rd_fire;

  memory_clear_seq #(
    .AWIDTH         (AWIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .busy_o     (busy)
  );

  assign wr_fire = wr_i & ~busy;
  assign rd_fire = rd_i & ~busy;

  // The array has no reset; the sequencer owns the write port while busy.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Write-first forwards only the enabled bytes of a same-address write.
  always_comb begin
    rd_word = mem_q[rd_addr_i];
    if (WrFirst && wr_fire && (wr_addr_i == rd_addr_i)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_be_i[i]) rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_fire;
    if (rd_fire) rd_data_d = rd_word;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: a read-first and a write-first instance share
// the same stimulus and are checked against a queue of expected read results.
module tb_memory_dp;

  typedef struct {
    logic [15:0] exp0;
    logic [15:0] exp1;
    string       tag;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  wrAddr = '0;
  logic [15:0] wrData = '0;
  logic [1:0]  wrBe = '0;
  logic        rd = 1'b0;
  logic [4:0]  rdAddr = '0;
  logic [15:0] rdData0, rdData1;
  logic        rdValid0, rdValid1, busy0, busy1;

  int          checks = 0;
  int          errors = 0;
  sb_item_t    sbQueue[$];
  logic [15:0] lastData0 = '0;
  logic [15:0] lastData1 = '0;

  always #5 clk = ~clk;

  memory_dp #(.AWIDTH(5), .DWIDTH(16), .RD_MODE(0), .CLEAR_ON_RESET(1)) dutRf (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .wr_be_i(wrBe), .rd_i(rd), .rd_addr_i(rdAddr), .rd_data_o(rdData0),
    .rd_valid_o(rdValid0), .busy_o(busy0)
  );

  memory_dp #(.AWIDTH(5), .DWIDTH(16), .RD_MODE(1), .CLEAR_ON_RESET(1)) dutWf (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .wr_be_i(wrBe), .rd_i(rd), .rd_addr_i(rdAddr), .rd_data_o(rdData1),
    .rd_valid_o(rdValid1), .busy_o(busy1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compares both instances after an edge; a pushed item is consumed whenever
  // a read was expected, otherwise rd_data must hold its previous value.
  task automatic checkOutput(input string tag, input logic expValid);
    sb_item_t item;
    check({tag, "_valid_rf"}, 32'(rdValid0), 32'(expValid));
    check({tag, "_valid_wf"}, 32'(rdValid1), 32'(expValid));
    if (expValid && sbQueue.size() > 0) begin
      item = sbQueue.pop_front();
      check({item.tag, "_data_rf"}, 32'(rdData0), 32'(item.exp0));
      check({item.tag, "_data_wf"}, 32'(rdData1), 32'(item.exp1));
      lastData0 = item.exp0;
      lastData1 = item.exp1;
    end else begin
      check({tag, "_hold_rf"}, 32'(rdData0), 32'(lastData0));
      check({tag, "_hold_wf"}, 32'(rdData1), 32'(lastData1));
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [15:0] wd,
                               input logic [1:0] be, input logic r, input logic [4:0] ra,
                               input logic expValid, input logic [15:0] e0,
                               input logic [15:0] e1, input string tag);
    sb_item_t item;
    wr = w; wrAddr = wa; wrData = wd; wrBe = be;
    rd = r; rdAddr = ra;
    if (expValid) begin
      item.exp0 = e0; item.exp1 = e1; item.tag = tag;
      sbQueue.push_back(item);
    end
    @(posedge clk); #1;
    checkOutput(tag, expValid);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, tag);
  endtask

  // Issues reads every cycle while busy and returns how many edges busy lasted.
  task automatic waitClear(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    while (busy0 && cycles < maxCycles) begin
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'(cycles), 1'b0, 16'h0, 16'h0, tag);
      cycles++;
    end
    check({tag, "_busy_wf"}, 32'(busy1), 32'(busy0));
  endtask

  initial begin
    int n;

    // Test 1: reset, clear duration, reads ignored while busy, cleared contents
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy0), 32'd1);
    check("reset_valid", 32'(rdValid0), 32'd0);
    check("reset_data", 32'(rdData0), 32'd0);
    rst = 1'b0;
    waitClear("clear1", 100, n);
    check("clear1_cycles", 32'(n), 32'd32);
    rd = 1'b0;
    for (int a = 0; a < 32; a++)
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'(a), 1'b1, 16'h0000, 16'h0000, "zero_rd");
    idle("zero_idle");

    // Test 2: full-word writes at both ends of the address range
    applyStimulus(1'b1, 5'd0,  16'hA5A5, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "wr0");
    applyStimulus(1'b1, 5'd31, 16'h5A5A, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "wr31");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd0,  1'b1, 16'hA5A5, 16'hA5A5, "rd0");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd31, 1'b1, 16'h5A5A, 16'h5A5A, "rd31");

    // Test 3: byte enables, including the all-zero no-op
    applyStimulus(1'b1, 5'd3, 16'hFFFF, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "be_full");
    applyStimulus(1'b1, 5'd3, 16'h1234, 2'b01, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "be_low");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3, 1'b1, 16'hFF34, 16'hFF34, "be_rd1");
    applyStimulus(1'b1, 5'd3, 16'h0000, 2'b00, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "be_none");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3, 1'b1, 16'hFF34, 16'hFF34, "be_rd2");

    // Test 4: same-address read during write, differing only in returned data
    applyStimulus(1'b1, 5'd7, 16'h1111, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "col_init");
    applyStimulus(1'b1, 5'd7, 16'h2222, 2'b10, 1'b1, 5'd7, 1'b1, 16'h1111, 16'h2211, "col");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd7, 1'b1, 16'h2211, 16'h2211, "col_after");
    // Independent write and read to different addresses in one cycle
    applyStimulus(1'b1, 5'd8, 16'hC3C3, 2'b11, 1'b1, 5'd3, 1'b1, 16'hFF34, 16'hFF34, "indep");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd8, 1'b1, 16'hC3C3, 16'hC3C3, "indep_rd");

    // Test 5: descending fill, back-to-back readback, then hold
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, 5'(31 - i), 16'(i), 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "fill_wr");
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'(31 - i), 1'b1, 16'(i), 16'(i), "fill_rd");
    idle("fill_hold1");
    idle("fill_hold2");

    // Test 6: reset in the middle of a clear restarts it from address 0
    applyStimulus(1'b1, 5'd20, 16'hBEEF, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0, 16'h0, "pre_wr20");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd20, 1'b1, 16'hBEEF, 16'hBEEF, "pre_rd20");
    rd = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lastData0 = '0; lastData1 = '0;
    repeat (10) @(posedge clk);
    #1;
    check("midclr_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midclr_rst_busy", 32'(busy0), 32'd1);
    check("midclr_rst_data", 32'(rdData1), 32'd0);
    rst = 1'b0;
    waitClear("clear2", 100, n);
    check("clear2_cycles", 32'(n), 32'd32);
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd20, 1'b1, 16'h0000, 16'h0000, "post_rd20");
    applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd31, 1'b1, 16'h0000, 16'h0000, "post_rd31");
    idle("end_idle");

    check("sb_drained", 32'(sbQueue.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
